// File: rtl/display_scan_if.sv
// rtl/display_scan_if.sv - scan controller value/enable inputs and display pin outputs
interface display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [3:0]              digit_code;
  logic [NUM_DIGITS-1:0]   an;
  logic                    dp_n;
  logic                    frame_start;

  modport master (
    output en, value, dp_mask,
    input  digit_code, an, dp_n, frame_start
  );

  modport slave (
    input  en, value, dp_mask,
    output digit_code, an, dp_n, frame_start
  );
endinterface

// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - multiplexed 7-segment scan with per-frame snapshot and LZ blanking
module display_scan_controller #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000,
  parameter int LZ_SUPPRESS     = 1
) (
  input logic           clk,
  input logic           rst,
  display_scan_if.slave bus
);
  localparam int MAXT = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam int IW   = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    take;
  logic [4*NUM_DIGITS-1:0] snap_code, snap_code_nxt, codes_in;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nxt;
  logic [3:0]              code_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    dp_n_nxt;
  logic                    lead;
  logic [3:0]              nib;

  // Codes are resolved once per frame so the scan path only indexes a stored vector.
  always_comb begin
    codes_in = '0;
    lead     = (LZ_SUPPRESS != 0);
    nib      = 4'h0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib = bus.value[4*i +: 4];
      if (nib > 4'd9) begin
        codes_in[4*i +: 4] = 4'hF;
        lead               = 1'b0;
      end else if (nib == 4'd0 && lead && i != 0) begin
        codes_in[4*i +: 4] = 4'hF;
      end else begin
        codes_in[4*i +: 4] = nib;
        if (nib != 4'd0) lead = 1'b0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    take      = 1'b0;
    if (!bus.en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          take      = 1'b1;
        end
        BLANK: begin
          if (cnt == CW'(BLANK_TICKS - 1)) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        SHOW: begin
          if (cnt == CW'(TICKS_PER_DIGIT - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == IW'(NUM_DIGITS - 1)) begin
              idx_nxt = '0;
              take    = 1'b1;
            end else begin
              idx_nxt = idx + IW'(1);
            end
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end

    snap_code_nxt = take ? codes_in : snap_code;
    snap_dp_nxt   = take ? bus.dp_mask : snap_dp;

    // Outputs follow the next state so every pin is a plain register.
    code_nxt = 4'hF;
    an_nxt   = '1;
    dp_n_nxt = 1'b1;
    if (state_nxt != IDLE) code_nxt = snap_code_nxt[4*idx_nxt +: 4];
    if (state_nxt == SHOW) begin
      an_nxt[idx_nxt] = 1'b0;
      dp_n_nxt        = ~snap_dp_nxt[idx_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      cnt             <= '0;
      snap_code       <= '0;
      snap_dp         <= '0;
      bus.digit_code  <= 4'hF;
      bus.an          <= '1;
      bus.dp_n        <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      state           <= state_nxt;
      idx             <= idx_nxt;
      cnt             <= cnt_nxt;
      snap_code       <= snap_code_nxt;
      snap_dp         <= snap_dp_nxt;
      bus.digit_code  <= code_nxt;
      bus.an          <= an_nxt;
      bus.dp_n        <= dp_n_nxt;
      bus.frame_start <= take;
    end
  end
endmodule
